// File: rtl/blink_scheduler_if.sv
// Request/grant bundle between the requester logic and blink_scheduler.
// The master modport drives requests and burst lengths. The slave modport drives grant, LED, done and busy.
interface blink_scheduler_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned BL_W = 4 * N_REQ;

    logic [N_REQ-1:0] req;
    logic [BL_W-1:0]  burst_len;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] led;
    logic [N_REQ-1:0] done;
    logic             busy;

    modport master (
        output req,
        output burst_len,
        input  grant,
        input  led,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        input  burst_len,
        output grant,
        output led,
        output done,
        output busy
    );
endinterface

// File: rtl/blink_scheduler.sv
// Shared blink-timing controller: arbitrates requesters onto one ON/OFF phase timer.
// Define BLINK_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module blink_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ON_CYCLES  = 50000000,
    parameter int unsigned OFF_CYCLES = 25000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    blink_scheduler_if.slave sched
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_FIN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_led;
    logic [N_REQ-1:0] r_done;
    logic             r_busy;
    logic [N_REQ-1:0] w_grant_nxt;
    logic [N_REQ-1:0] w_led_nxt;
    logic [N_REQ-1:0] w_done_nxt;

    logic             w_any_req;
    logic             w_abort;
    logic             w_fin_exit;
    logic             w_on_end;
    logic             w_off_end;
    logic [IDX_W-1:0] w_win;
    logic [LEN_W-1:0] w_win_len;

    assign w_any_req  = |sched.req;
    assign w_abort    = ((r_state == ST_ON) || (r_state == ST_OFF)) && !sched.req[r_idx];
    // FIN lasts until its done pulse has been emitted.
    assign w_fin_exit = (r_state == ST_FIN) && (|r_done);
    assign w_on_end   = (r_timer == CNT_W'(ON_CYCLES - 1));
    assign w_off_end  = (r_timer == CNT_W'(OFF_CYCLES - 1));

`ifdef BLINK_SCHED_FIXED_PRIO_EN
    // Lowest set request index wins.
    always_comb begin
        w_win     = '0;
        w_win_len = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (sched.req[i]) begin
                w_win     = IDX_W'(i);
                w_win_len = sched.burst_len[{IDX_W'(i), 2'b00} +: LEN_W];
            end
        end
    end
`else
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Round-robin search starting at the pointer, wrapping at N_REQ.
    always_comb begin
        w_win     = '0;
        w_win_len = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = IDX_W'((32'(r_ptr) + k) % N_REQ);
            if (!w_found && sched.req[w_cand]) begin
                w_found   = 1'b1;
                w_win     = w_cand;
                w_win_len = sched.burst_len[{w_cand, 2'b00} +: LEN_W];
            end
        end
    end

    // Pointer moves past the served index on completion or abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_abort || w_fin_exit) begin
            r_ptr <= (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_rem   <= '0;
            r_timer <= '0;
            r_grant <= '0;
            r_led   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rem   <= w_rem_nxt;
            r_timer <= w_timer_nxt;
            r_grant <= w_grant_nxt;
            r_led   <= w_led_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rem_nxt   = r_rem;
        w_timer_nxt = r_timer;
        w_grant_nxt = '0;
        w_led_nxt   = '0;
        w_done_nxt  = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_idx_nxt   = w_win;
                    w_rem_nxt   = w_win_len;
                    w_timer_nxt = '0;
                    w_state_nxt = (w_win_len != '0) ? ST_ON : ST_FIN;
                end
            end
            ST_ON: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end else if (w_on_end) begin
                    w_state_nxt = ST_OFF;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end else if (w_off_end) begin
                    w_timer_nxt = '0;
                    w_rem_nxt   = (r_rem != '0) ? r_rem - LEN_W'(1) : r_rem;
                    w_state_nxt = (r_rem <= LEN_W'(1)) ? ST_FIN : ST_ON;
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            ST_FIN: begin
                w_timer_nxt = '0;
                if (w_fin_exit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase

        // A zero-length burst spends one granted, dark cycle in FIN before its done pulse.
        unique case (w_state_nxt)
            ST_ON: begin
                w_grant_nxt = N_REQ'(1) << w_idx_nxt;
                w_led_nxt   = N_REQ'(1) << w_idx_nxt;
            end
            ST_OFF: begin
                w_grant_nxt = N_REQ'(1) << w_idx_nxt;
            end
            ST_FIN: begin
                if (r_state == ST_IDLE) begin
                    w_grant_nxt = N_REQ'(1) << w_idx_nxt;
                end else begin
                    w_done_nxt = N_REQ'(1) << w_idx_nxt;
                end
            end
            default: begin
                w_grant_nxt = '0;
            end
        endcase
    end

    assign sched.grant = r_grant;
    assign sched.led   = r_led;
    assign sched.done  = r_done;
    assign sched.busy  = r_busy;
endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler with N_REQ=4, ON_CYCLES=4, OFF_CYCLES=2.
module tb_blink_scheduler;
    localparam int unsigned N_REQ = 4;
    localparam int          ON_C  = 4;
    localparam int          OFF_C = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    blink_scheduler_if #(.N_REQ(N_REQ)) bus ();

    blink_scheduler #(
        .N_REQ     (N_REQ),
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .CNT_W     (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sched(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_len(input int idx, input logic [3:0] val);
        bus.burst_len[4*idx +: 4] = val;
    endtask

    task automatic do_reset();
        bus.req       = '0;
        bus.burst_len = '0;
        reset         = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Walk one grant window from its first cycle; exits on the cycle grant changes.
    task automatic measure(input int idx, output int g, output int ledc, output int blinks,
                           output int pat_err);
        logic [3:0] oh;
        logic       prev;
        logic       lit;
        oh      = 4'(1) << idx;
        g       = 0;
        ledc    = 0;
        blinks  = 0;
        pat_err = 0;
        prev    = 1'b0;
        while (bus.grant == oh && g < 200) begin
            lit = (bus.led == oh);
            if (lit) ledc++;
            else if (bus.led != 4'b0) pat_err++;
            if (lit != ((g % (ON_C + OFF_C)) < ON_C)) pat_err++;
            if (lit && !prev) blinks++;
            prev = lit;
            g++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         g, lc, bl, pe, idle, to, widx;
        logic [3:0] exp_g;

        reset         = 1'b1;
        bus.req       = '0;
        bus.burst_len = '0;
        #1;
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_led", 32'(bus.led), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        step();
        step();
        reset = 1'b0;

        // Single request, three blinks.
        set_len(1, 4'd3);
        bus.req = 4'b0010;
        step();
        chk("t1_grant_rise", 32'(bus.grant), 32'h2);
        chk("t1_led_rise", 32'(bus.led), 32'h2);
        measure(1, g, lc, bl, pe);
        chk("t1_grant_cycles", 32'(g), 18);
        chk("t1_led_cycles", 32'(lc), 12);
        chk("t1_blinks", 32'(bl), 3);
        chk("t1_pattern_err", 32'(pe), 0);
        chk("t1_done", 32'(bus.done), 32'h2);
        chk("t1_busy_fin", 32'(bus.busy), 1);
        bus.req = 4'b0000;
        step();
        chk("t1_busy_fall", 32'(bus.busy), 0);
        chk("t1_done_once", 32'(bus.done), 0);

        // Fairness with all requesters held.
        do_reset();
        bus.burst_len = 16'h1111;
        bus.req       = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
`ifdef BLINK_SCHED_FIXED_PRIO_EN
            widx = 0;
`else
            widx = k % 4;
`endif
            exp_g = 4'(1) << widx;
            chk($sformatf("t2_grant%0d", k), 32'(bus.grant), 32'(exp_g));
            measure(widx, g, lc, bl, pe);
            chk($sformatf("t2_len%0d", k), 32'(g), 6);
            chk($sformatf("t2_done%0d", k), 32'(bus.done), 32'(exp_g));
            step();
            idle = 0;
            to   = 0;
            while (bus.grant == 4'b0 && to < 10) begin
                if (!bus.busy) idle++;
                to++;
                step();
            end
            chk($sformatf("t2_idle%0d", k), 32'(idle), 1);
        end

        // Zero-length burst.
        do_reset();
        set_len(2, 4'd0);
        bus.req = 4'b0100;
        step();
        chk("t3_grant", 32'(bus.grant), 32'h4);
        chk("t3_led", 32'(bus.led), 0);
        chk("t3_no_early_done", 32'(bus.done), 0);
        step();
        chk("t3_grant_fall", 32'(bus.grant), 0);
        chk("t3_done", 32'(bus.done), 32'h4);
        chk("t3_led_fin", 32'(bus.led), 0);
        bus.req = 4'b0000;
        step();
        chk("t3_busy_fall", 32'(bus.busy), 0);

        // Abort in the second cycle of the second OFF phase; req[3] pending.
        do_reset();
        set_len(0, 4'd3);
        set_len(3, 4'd1);
        bus.req = 4'b1001;
        repeat (12) step();
        chk("t4_pre_grant", 32'(bus.grant), 32'h1);
        chk("t4_pre_led", 32'(bus.led), 0);
        bus.req = 4'b1000;
        step();
        chk("t4_abort_grant", 32'(bus.grant), 0);
        chk("t4_abort_led", 32'(bus.led), 0);
        chk("t4_abort_done", 32'(bus.done), 0);
        chk("t4_abort_busy", 32'(bus.busy), 0);
        step();
        chk("t4_next_grant", 32'(bus.grant), 32'h8);
        measure(3, g, lc, bl, pe);
        chk("t4_next_len", 32'(g), 6);
        chk("t4_next_done", 32'(bus.done), 32'h8);
        bus.req = 4'b0000;
        step();

        // Asynchronous reset during an ON phase.
        do_reset();
        set_len(0, 4'd2);
        bus.req = 4'b0001;
        step();
        step();
        chk("t5_led_before", 32'(bus.led), 32'h1);
        reset = 1'b1;
        #1;
        chk("t5_async_grant", 32'(bus.grant), 0);
        chk("t5_async_led", 32'(bus.led), 0);
        chk("t5_async_busy", 32'(bus.busy), 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("t5_regrant", 32'(bus.grant), 32'h1);
        measure(0, g, lc, bl, pe);
        chk("t5_len", 32'(g), 12);
        chk("t5_blinks", 32'(bl), 2);
        chk("t5_pattern_err", 32'(pe), 0);
        chk("t5_done", 32'(bus.done), 32'h1);
        bus.req = 4'b0000;
        step();

        // burst_len change after grant is ignored.
        do_reset();
        set_len(1, 4'd2);
        bus.req = 4'b0010;
        step();
        chk("t6_grant", 32'(bus.grant), 32'h2);
        set_len(1, 4'd5);
        measure(1, g, lc, bl, pe);
        chk("t6_len", 32'(g), 12);
        chk("t6_led_cycles", 32'(lc), 8);
        chk("t6_blinks", 32'(bl), 2);
        chk("t6_done", 32'(bus.done), 32'h2);
        bus.req = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
